cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  instruction opcode field of the instruction register.
REQ-005 zero  input  1  ALU zero flag, valid in EXEC.
REQ-006 mem_ack  input  1  shared single-port memory completion; sampled on clk only while mem_req=1.
REQ-007 mem_req  output  1  memory access request.
REQ-008 mem_we  output  1  write strobe; meaningful only with mem_req.
REQ-009 mem_sel  output  1  address select: 0 = PC (fetch), 1 = ALU result (data).
REQ-010 irWrite, pcWrite, pcSrc, aluEn, regWrite  output  1 each  datapath strobes (pcSrc: 0 = PC+4, 1 = branch/jump target).
REQ-011 state  output  3  current state code.
REQ-012 halted  output  1  high in HALT.
REQ-013 instr_count  output  16  retired-instruction counter.

Function
REQ-014 States and codes SHALL be: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6-7 SHALL go to FETCH on the next edge.
REQ-015 Opcode classes SHALL be:
- LOAD = 010000
- STORE = 011000
- HALT = 111111
- BRANCH = opcode[5:4]==10
- JUMP = opcode[5:4]==11, excluding HALT
- ALU = opcode[5:4]==00
- Any other 01xxxx opcode is a NOP.
REQ-016 All strobes SHALL be Moore outputs decoded from state and opcode, except irWrite and pcWrite in FETCH, which are mem_req & mem_ack.
REQ-017 FETCH: mem_req=1, mem_we=0, mem_sel=0. On an edge with mem_ack=1: irWrite=1, pcWrite=1, pcSrc=0, next state DECODE. Otherwise the block stays in FETCH with no limit on wait cycles.
REQ-018 DECODE: one cycle, no strobes. HALT opcode -> HALT; all others -> EXEC.
REQ-019 EXEC: one cycle, aluEn=1. Next state by class:
- LOAD or STORE -> MEM
- ALU -> WB
- BRANCH -> FETCH; pcWrite=1 and pcSrc=1 only if zero=1
- JUMP -> FETCH; pcWrite=1 and pcSrc=1 unconditionally
- NOP -> FETCH
REQ-020 MEM: mem_req=1, mem_sel=1, mem_we=1 for STORE only. On mem_ack: LOAD -> WB, STORE -> FETCH. Without mem_ack the block holds MEM.
REQ-021 WB: one cycle, regWrite=1, next state FETCH.
REQ-022 HALT: absorbing state; all strobes 0, halted=1. Only rst exits HALT.
REQ-023 instr_count SHALL increment by 1, wrapping modulo 2^16 (FFFF -> 0000), on every transition into FETCH from EXEC, MEM or WB. Entering HALT SHALL NOT increment it.
REQ-024 mem_ack while mem_req=0 SHALL be ignored.
REQ-025 A mem_ack present in the first cycle of FETCH or MEM SHALL complete the access in that cycle (minimum fetch = 1 cycle).
REQ-026 Latency with zero memory wait states:
- ALU and LOAD: 4 and 5 cycles.
- STORE: 4 cycles.
- BRANCH, JUMP and NOP: 3 cycles.
REQ-027 opcode SHALL be treated as stable from DECODE through the end of the instruction; the block does not latch it.

Reset
REQ-028 While rst=1, outputs SHALL be forced asynchronously to: state=FETCH, instr_count=0, halted=0, and all strobes and mem_req=0.
REQ-029 Assertion of rst mid-FETCH or mid-MEM SHALL drop mem_req in the same cycle with no write strobe.
REQ-030 The first edge after rst deasserts SHALL evaluate FETCH normally.

Structure
REQ-031 State codes, opcode class constants (LOAD, STORE, HALT) and the counter width SHALL live in a shared package pRISC_pkg, also used by Controller.
REQ-032 One sub-module, opcode_class, SHALL decode opcode into one-hot class flags (alu, load, store, branch, jump, halt, nop). The FSM and counter SHALL stay in cpu_sequencer.

Verification
REQ-033 ALU op 000001, mem_ack held 1:
- state sequence 0,1,2,4,0
- regWrite high exactly in cycle 4
- instr_count 0 -> 1
REQ-034 LOAD 010000, mem_ack low 3 cycles in MEM:
- mem_req=1, mem_sel=1, mem_we=0 for 4 cycles
- then WB with regWrite=1
- total 8 cycles
REQ-035 STORE 011000 with ack=1: mem_we=1 for exactly one cycle, no regWrite, MEM -> FETCH.
REQ-036 BRANCH 100000:
- zero=1: pcWrite=1 and pcSrc=1 in EXEC.
- zero=0: pcWrite=0 in EXEC.
- JUMP 110000: pcWrite=1 regardless of zero.
REQ-037 HALT 111111: halted=1 and state=5 held for 20 cycles, instr_count unchanged; rst pulse -> state=0, halted=0, instr_count=0.
REQ-038 rst asserted mid-MEM: mem_req=0 within the same cycle. Separately, preload instr_count=FFFF and retire one instruction -> 0000.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the pRISC control path: state codes, fixed
// opcodes, the one-hot opcode class record and the retired-instruction
// counter width. The Controller imports this package as well.
package pRISC_pkg;

    localparam int COUNT_WIDTH = 16;

    localparam logic [5:0] OP_LOAD  = 6'b010000;
    localparam logic [5:0] OP_STORE = 6'b011000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    // Exactly one flag is set for any opcode value.
    typedef struct packed {
        logic alu;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic halt;
        logic nop;
    } opClass_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bundle between the sequencer and the datapath/memory side. The master
// modport is the sequencer; the slave modport is whoever supplies the
// opcode, zero flag and memory acknowledge.
interface cpu_sequencer_if;
    import pRISC_pkg::*;

    logic [5:0]             opcode;
    logic                   zero;
    logic                   mem_ack;
    logic                   mem_req;
    logic                   mem_we;
    logic                   mem_sel;
    logic                   irWrite;
    logic                   pcWrite;
    logic                   pcSrc;
    logic                   aluEn;
    logic                   regWrite;
    logic [2:0]             state;
    logic                   halted;
    logic [COUNT_WIDTH-1:0] instr_count;

    modport master (
        input  opcode, zero, mem_ack,
        output mem_req, mem_we, mem_sel, irWrite, pcWrite, pcSrc,
               aluEn, regWrite, state, halted, instr_count
    );

    modport slave (
        output opcode, zero, mem_ack,
        input  mem_req, mem_we, mem_sel, irWrite, pcWrite, pcSrc,
               aluEn, regWrite, state, halted, instr_count
    );

endinterface

// File: rtl/cpu_sequencer_opcode_class.sv
// Opcode classifier: turns the 6-bit opcode into one-hot class flags.
// HALT is carved out of the 11xxxx jump space; the two fixed memory
// opcodes are carved out of 01xxxx, and the rest of 01xxxx is NOP.
module opcode_class
    import pRISC_pkg::*;
(
    input  logic [5:0] opcode_i,
    output opClass_t   cls_o
);

    // Classify the opcode, checking HALT first since it overlaps the jump space
    always_comb begin
        cls_o = '0;
        if (opcode_i == OP_HALT) begin
            cls_o.halt = 1'b1;
        end else begin
            case (opcode_i[5:4])
                2'b00:   cls_o.alu    = 1'b1;
                2'b10:   cls_o.branch = 1'b1;
                2'b11:   cls_o.jump   = 1'b1;
                default: begin
                    if (opcode_i == OP_LOAD) begin
                        cls_o.load = 1'b1;
                    end else if (opcode_i == OP_STORE) begin
                        cls_o.store = 1'b1;
                    end else begin
                        cls_o.nop = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT state
// machine plus the retired-instruction counter. The opcode is not latched
// here; the instruction register holds it stable for the whole instruction.
// Strobes are decoded from the current state (and the opcode), except the
// fetch-completion strobes which follow the memory acknowledge directly.
module cpu_sequencer
    import pRISC_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    cpu_sequencer_if.master bus
);

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    opClass_t               cls;

    logic memReq, memWe, memSel, irWr, pcWr, pcSel, aluOn, regWr, haltFlag;

    opcode_class u_opcode_class (
        .opcode_i (bus.opcode),
        .cls_o    (cls)
    );

    // Next state and counter; every return to FETCH from EXEC/MEM/WB retires one instruction
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ack) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = cls.halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (cls.load || cls.store) begin
                    state_d = S_MEM;
                end else if (cls.alu) begin
                    state_d = S_WB;
                end else if (cls.branch || cls.jump || cls.nop || cls.halt) begin
                    state_d = S_FETCH;
                    count_d = count_q + COUNT_WIDTH'(1);
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (bus.mem_ack) begin
                    if (cls.store) begin
                        state_d = S_FETCH;
                        count_d = count_q + COUNT_WIDTH'(1);
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                count_d = count_q + COUNT_WIDTH'(1);
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State and counter registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Strobe decode; everything is held low while rst is asserted so a reset mid-access drops the request at once
    always_comb begin
        memReq   = 1'b0;
        memWe    = 1'b0;
        memSel   = 1'b0;
        irWr     = 1'b0;
        pcWr     = 1'b0;
        pcSel    = 1'b0;
        aluOn    = 1'b0;
        regWr    = 1'b0;
        haltFlag = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    memReq = 1'b1;
                    irWr   = bus.mem_ack;
                    pcWr   = bus.mem_ack;
                end
                S_EXEC: begin
                    aluOn = 1'b1;
                    if (cls.jump || (cls.branch && bus.zero)) begin
                        pcWr  = 1'b1;
                        pcSel = 1'b1;
                    end
                end
                S_MEM: begin
                    memReq = 1'b1;
                    memSel = 1'b1;
                    memWe  = cls.store;
                end
                S_WB: begin
                    regWr = 1'b1;
                end
                S_HALT: begin
                    haltFlag = 1'b1;
                end
                default: begin
                    memReq = 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req     = memReq;
    assign bus.mem_we      = memWe;
    assign bus.mem_sel     = memSel;
    assign bus.irWrite     = irWr;
    assign bus.pcWrite     = pcWr;
    assign bus.pcSrc       = pcSel;
    assign bus.aluEn       = aluOn;
    assign bus.regWrite    = regWr;
    assign bus.halted      = haltFlag;
    assign bus.state       = state_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer. applyStimulus expands one instruction into its
// expected per-cycle trace (inputs to drive plus expected outputs) and
// pushes it on a queue; checkOutput pops entries, drives their inputs and
// compares the DUT outputs a little after each falling edge.
module tb_cpu_sequencer;

    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic        ack;
        logic [2:0]  st;
        logic [8:0]  strb;
        logic [15:0] cnt;
    } step_t;

    logic        clk;
    logic        rst;
    step_t       sb[$];
    logic [15:0] expCount;
    int          checks;
    int          errors;
    int          stepNo;

    cpu_sequencer_if seqBus ();

    cpu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (seqBus)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Strobe order: mem_req, mem_we, mem_sel, irWrite, pcWrite, pcSrc, aluEn, regWrite, halted
    function automatic logic [8:0] dutStrobes();
        return {seqBus.mem_req, seqBus.mem_we, seqBus.mem_sel, seqBus.irWrite,
                seqBus.pcWrite, seqBus.pcSrc, seqBus.aluEn, seqBus.regWrite,
                seqBus.halted};
    endfunction

    // Count one comparison and report it if it differs
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s (step %0d): observed 0x%0h required 0x%0h", tag, stepNo, obs, exp);
        end
    endtask

    task automatic push(input logic [5:0] op, input logic z, input logic ack,
                        input logic [2:0] st, input logic [8:0] strb);
        step_t s;
        s.op = op; s.z = z; s.ack = ack; s.st = st; s.strb = strb; s.cnt = expCount;
        sb.push_back(s);
    endtask

    // Build the expected cycle trace of one instruction from the bench's own opcode model
    task automatic applyStimulus(input logic [5:0] op, input logic z,
                                 input int fetchWait, input int memWait);
        logic isHalt, isLoad, isStore, isAlu, isBranch, isJump, pcw;
        isHalt   = (op == 6'b111111);
        isLoad   = (op == 6'b010000);
        isStore  = (op == 6'b011000);
        isAlu    = (op[5:4] == 2'b00);
        isBranch = (op[5:4] == 2'b10);
        isJump   = (op[5:4] == 2'b11) && !isHalt;
        pcw      = isJump || (isBranch && z);
        for (int i = 0; i < fetchWait; i++) push(op, z, 1'b0, 3'd0, 9'b100000000);
        push(op, z, 1'b1, 3'd0, 9'b100110000);
        push(op, z, 1'b1, 3'd1, 9'b000000000);
        if (isHalt) begin
            for (int i = 0; i < 20; i++) push(op, z, 1'b1, 3'd5, 9'b000000001);
        end else begin
            push(op, z, 1'b1, 3'd2, {4'b0000, pcw, pcw, 1'b1, 2'b00});
            if (isLoad || isStore) begin
                for (int i = 0; i < memWait; i++) push(op, z, 1'b0, 3'd3, {1'b1, isStore, 1'b1, 6'b0});
                push(op, z, 1'b1, 3'd3, {1'b1, isStore, 1'b1, 6'b0});
            end
            if (isLoad || isAlu) push(op, z, 1'b1, 3'd4, 9'b000000010);
            expCount++;
        end
    endtask

    // Pop n entries (all if n < 0); called at a falling edge, returns at a falling edge
    task automatic checkOutput(input int n);
        step_t s;
        int k;
        k = 0;
        while (sb.size() > 0 && (n < 0 || k < n)) begin
            s = sb.pop_front();
            seqBus.opcode  = s.op;
            seqBus.zero    = s.z;
            seqBus.mem_ack = s.ack;
            #1;
            check("state", 32'(seqBus.state), 32'(s.st));
            check("strobes", 32'(dutStrobes()), 32'(s.strb));
            check("instr_count", 32'(seqBus.instr_count), 32'(s.cnt));
            stepNo++;
            k++;
            @(negedge clk);
        end
    endtask

    // Directed sequence
    initial begin
        checks   = 0;
        errors   = 0;
        stepNo   = 0;
        expCount = 16'h0000;
        rst              = 1'b1;
        seqBus.opcode    = 6'b000001;
        seqBus.zero      = 1'b0;
        seqBus.mem_ack   = 1'b1;

        // Reset state, with a stray acknowledge that must not raise fetch strobes
        #3;
        check("reset state", 32'(seqBus.state), 32'd0);
        check("reset strobes", 32'(dutStrobes()), 32'd0);
        check("reset count", 32'(seqBus.instr_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Main instruction mix
        applyStimulus(6'b000001, 1'b0, 0, 0);   // ALU
        applyStimulus(6'b010000, 1'b0, 0, 3);   // LOAD with 3 wait cycles
        applyStimulus(6'b011000, 1'b0, 0, 0);   // STORE
        applyStimulus(6'b011000, 1'b1, 2, 1);   // STORE with fetch and mem waits
        applyStimulus(6'b100000, 1'b1, 0, 0);   // BRANCH taken
        applyStimulus(6'b100000, 1'b0, 0, 0);   // BRANCH not taken
        applyStimulus(6'b110000, 1'b0, 0, 0);   // JUMP with zero=0
        applyStimulus(6'b010101, 1'b1, 0, 0);   // NOP
        applyStimulus(6'b001010, 1'b1, 1, 0);   // ALU
        applyStimulus(6'b010000, 1'b1, 0, 0);   // LOAD, no waits
        checkOutput(-1);

        // Counter wrap: preset near the top and retire two instructions
        dut.count_q = 16'hFFFF;
        expCount    = 16'hFFFF;
        applyStimulus(6'b010111, 1'b0, 0, 0);
        applyStimulus(6'b111000, 1'b0, 0, 0);
        checkOutput(-1);

        // Reset in the middle of a STORE data access
        applyStimulus(6'b011000, 1'b0, 0, 5);
        checkOutput(4);
        seqBus.mem_ack = 1'b0;
        #1;
        check("pre-reset mem_req", 32'(seqBus.mem_req), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid-MEM reset mem_req", 32'(seqBus.mem_req), 32'd0);
        check("mid-MEM reset mem_we", 32'(seqBus.mem_we), 32'd0);
        check("mid-MEM reset state", 32'(seqBus.state), 32'd0);
        check("mid-MEM reset count", 32'(seqBus.instr_count), 32'd0);
        sb.delete();
        expCount = 16'h0000;
        @(negedge clk);
        rst = 1'b0;

        // Normal fetch right after reset, then HALT which must not retire
        applyStimulus(6'b000011, 1'b0, 0, 0);
        applyStimulus(6'b111111, 1'b0, 0, 0);
        checkOutput(-1);

        // Only reset leaves HALT
        #1;
        rst = 1'b1;
        #1;
        check("halt reset state", 32'(seqBus.state), 32'd0);
        check("halt reset halted", 32'(seqBus.halted), 32'd0);
        check("halt reset count", 32'(seqBus.instr_count), 32'd0);
        expCount = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(6'b000111, 1'b0, 0, 0);
        checkOutput(-1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
